// File: rtl/mem_port_arbiter.sv
// Shares one Avalon-MM memory master between the instruction-fetch port and
// the data load/store port. Round-robin, one transaction per grant; the grant
// is held until every beat of a read burst has come back, so return data is
// steered by the current owner alone. Fetch data can be flushed after a jump.
module mem_port_arbiter #(
   parameter int p_addr_bits  = 32,
   parameter int p_data_bits  = 32,
   parameter int p_burst_bits = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [p_addr_bits-1:0]     i_inst_addr,
   input  logic                       i_inst_read,
   input  logic [p_burst_bits-1:0]    i_inst_burstcount,
   output logic                       o_inst_waitrequest,
   output logic [p_data_bits-1:0]     o_inst_readdata,
   output logic                       o_inst_readdatavalid,
   input  logic                       i_inst_flush,
   input  logic [p_addr_bits-1:0]     i_data_addr,
   input  logic                       i_data_read,
   input  logic                       i_data_write,
   input  logic [p_data_bits-1:0]     i_data_writedata,
   input  logic [p_data_bits/8-1:0]   i_data_byteenable,
   input  logic [p_burst_bits-1:0]    i_data_burstcount,
   output logic                       o_data_waitrequest,
   output logic [p_data_bits-1:0]     o_data_readdata,
   output logic                       o_data_readdatavalid,
   output logic [p_addr_bits-1:0]     o_addr,
   output logic                       o_read,
   output logic                       o_write,
   output logic [p_data_bits-1:0]     o_writedata,
   output logic [p_data_bits/8-1:0]   o_byteenable,
   output logic [p_burst_bits-1:0]    o_burstcount,
   input  logic                       i_waitrequest,
   input  logic [p_data_bits-1:0]     i_readdata,
   input  logic                       i_readdatavalid,
   output logic                       o_owner,
   output logic                       o_stray_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CMD   = 2'd1;
   localparam logic [1:0] ST_RDATA = 2'd2;

   localparam logic [p_burst_bits-1:0] ONE = p_burst_bits'(1);

   logic [1:0]              state_q, state_d;
   logic                    owner_q, owner_d;   // 0 = inst, 1 = data
   logic                    last_q, last_d;     // owner of the last completed transaction
   logic                    discard_q, discard_d;
   logic                    stray_q, stray_d;
   logic [p_burst_bits-1:0] cnt_q, cnt_d;
   logic [p_burst_bits-1:0] len_q, len_d;
   logic [p_burst_bits-1:0] cnt_inc;

   logic inst_req, data_req, own_req, own_wr, in_cmd, in_rdata;

   assign inst_req = i_inst_read;
   assign data_req = i_data_read | i_data_write;
   assign own_req  = owner_q ? data_req : inst_req;
   assign own_wr   = owner_q & i_data_write;      // write wins over a simultaneous read
   assign in_cmd   = (state_q == ST_CMD);
   assign in_rdata = (state_q == ST_RDATA);
   assign cnt_inc  = cnt_q + ONE;

   assign o_owner     = owner_q;
   assign o_stray_err = stray_q;

   // Command path: the owner's request passes straight through while in CMD.
   always_comb begin
      o_addr             = owner_q ? i_data_addr : i_inst_addr;
      o_writedata        = i_data_writedata;
      o_byteenable       = owner_q ? i_data_byteenable : '1;
      o_burstcount       = owner_q ? i_data_burstcount : i_inst_burstcount;
      o_read             = 1'b0;
      o_write            = 1'b0;
      o_inst_waitrequest = 1'b1;
      o_data_waitrequest = 1'b1;
      if (in_cmd) begin
         if (owner_q) begin
            o_write            = i_data_write;
            o_read             = i_data_read & ~i_data_write;
            o_data_waitrequest = i_waitrequest;
         end else begin
            o_read             = i_inst_read;
            o_inst_waitrequest = i_waitrequest;
         end
      end
   end

   // Return path: data fans out to both ports, valid only to the owner;
   // a flushed fetch burst is still drained but no longer delivered.
   always_comb begin
      o_inst_readdata      = i_readdata;
      o_data_readdata      = i_readdata;
      o_inst_readdatavalid = in_rdata & i_readdatavalid & ~owner_q & ~discard_q & ~i_inst_flush;
      o_data_readdatavalid = in_rdata & i_readdatavalid & owner_q;
   end

   // Arbitration and transaction sequencing.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      discard_d = discard_q;
      stray_d   = stray_q;
      case (state_q)
         ST_IDLE: begin
            if (inst_req || data_req) begin
               state_d = ST_CMD;
               owner_d = (inst_req && data_req) ? ~last_q : data_req;
            end
         end
         ST_CMD: begin
            if (!own_req) begin
               state_d = ST_IDLE;               // request withdrawn, nothing issued
            end else if (!i_waitrequest) begin
               if (own_wr) begin
                  last_d  = owner_q;
                  state_d = ST_IDLE;
               end else begin
                  len_d   = (o_burstcount == '0) ? ONE : o_burstcount;
                  cnt_d   = '0;
                  state_d = ST_RDATA;
               end
            end
         end
         ST_RDATA: begin
            if (i_readdatavalid) begin
               cnt_d = cnt_inc;
               if (cnt_inc == len_q) begin
                  last_d  = owner_q;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (i_inst_flush && !owner_q && (in_cmd || in_rdata))
         discard_d = 1'b1;
      if (state_d == ST_IDLE)
         discard_d = 1'b0;
      if (i_readdatavalid && !in_rdata)
         stray_d = 1'b1;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         discard_q <= 1'b0;
         stray_q   <= 1'b0;
         cnt_q     <= '0;
         len_q     <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         discard_q <= discard_d;
         stray_q   <= stray_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// rounds, checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   i_inst_addr, i_data_addr, o_addr;
   logic            i_inst_read, o_inst_waitrequest, o_inst_readdatavalid, i_inst_flush;
   logic [BW-1:0]   i_inst_burstcount, i_data_burstcount, o_burstcount;
   logic [DW-1:0]   o_inst_readdata, o_data_readdata, i_data_writedata, o_writedata, i_readdata;
   logic            i_data_read, i_data_write, o_data_waitrequest, o_data_readdatavalid;
   logic [DW/8-1:0] i_data_byteenable, o_byteenable;
   logic            o_read, o_write, i_waitrequest, i_readdatavalid, o_owner, o_stray_err;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   bit last_m = 1'b1;   // model: owner of the last completed transaction

   always #5 clk = ~clk;

   mem_port_arbiter #(.p_addr_bits(AW), .p_data_bits(DW), .p_burst_bits(BW)) dut (
      .clk(clk), .rst(rst),
      .i_inst_addr(i_inst_addr), .i_inst_read(i_inst_read), .i_inst_burstcount(i_inst_burstcount),
      .o_inst_waitrequest(o_inst_waitrequest), .o_inst_readdata(o_inst_readdata),
      .o_inst_readdatavalid(o_inst_readdatavalid), .i_inst_flush(i_inst_flush),
      .i_data_addr(i_data_addr), .i_data_read(i_data_read), .i_data_write(i_data_write),
      .i_data_writedata(i_data_writedata), .i_data_byteenable(i_data_byteenable),
      .i_data_burstcount(i_data_burstcount), .o_data_waitrequest(o_data_waitrequest),
      .o_data_readdata(o_data_readdata), .o_data_readdatavalid(o_data_readdatavalid),
      .o_addr(o_addr), .o_read(o_read), .o_write(o_write), .o_writedata(o_writedata),
      .o_byteenable(o_byteenable), .o_burstcount(o_burstcount),
      .i_waitrequest(i_waitrequest), .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
      .o_owner(o_owner), .o_stray_err(o_stray_err)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_inst_read = 1'b0;  i_inst_flush = 1'b0;  i_data_read = 1'b0;  i_data_write = 1'b0;
      i_readdatavalid = 1'b0;  i_waitrequest = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      chk1("rst_read", o_read, 1'b0);
      chk1("rst_write", o_write, 1'b0);
      chk1("rst_inst_rdvalid", o_inst_readdatavalid, 1'b0);
      chk1("rst_data_rdvalid", o_data_readdatavalid, 1'b0);
      chk1("rst_stray", o_stray_err, 1'b0);
      chk1("rst_inst_wait", o_inst_waitrequest, 1'b1);
      chk1("rst_data_wait", o_data_waitrequest, 1'b1);
      chk1("rst_owner", o_owner, 1'b0);
      rst = 1'b0;
      last_m = 1'b1;
   endtask

   // One round: the selected requesters raise their requests together while
   // the arbiter is idle; the bench plays memory until every transaction ends.
   task automatic run_round(input bit ri, input bit rd, input bit dw, input bit dr,
                            input logic [BW-1:0] ib, input logic [BW-1:0] db,
                            input bit rnd, input int stall, input int flush_at,
                            input logic [DW-1:0] base,
                            input logic [AW-1:0] ia, input logic [AW-1:0] da,
                            input logic [DW-1:0] wd, input logic [DW/8-1:0] be);
      bit cur, accepted, disc, drop_i, drop_d, beat, fl, exp_iv, exp_dv, fin;
      int need, done_cnt, remaining, beat_idx, cmd_cycles, since, cyc;
      logic [DW-1:0] rdat;
      logic [BW-1:0] blen;
      i_inst_addr = ia;  i_inst_burstcount = ib;  i_inst_read = ri;
      i_data_addr = da;  i_data_writedata = wd;  i_data_byteenable = be;
      i_data_burstcount = db;  i_data_read = rd & dr;  i_data_write = rd & dw;
      need = int'(ri) + int'(rd);
      cur = (ri && rd) ? !last_m : !ri;
      done_cnt = 0; remaining = 0; beat_idx = 0; cmd_cycles = 0; since = 0;
      accepted = 1'b0; disc = 1'b0; drop_i = 1'b0; drop_d = 1'b0;
      for (cyc = 0; cyc < 400 && done_cnt < need; cyc++) begin
         if (drop_i) i_inst_read = 1'b0;
         if (drop_d) begin i_data_read = 1'b0; i_data_write = 1'b0; end
         drop_i = 1'b0; drop_d = 1'b0; fin = 1'b0;
         i_waitrequest = rnd ? ($urandom_range(0, 2) == 0) : (cmd_cycles < stall);
         beat = (remaining > 0) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
         rdat = rnd ? $urandom : base + beat_idx;
         fl = beat && (beat_idx == flush_at);
         i_readdatavalid = beat;  i_readdata = rdat;  i_inst_flush = fl;
         #1;
         exp_iv = beat && !cur && !disc && !fl;
         exp_dv = beat && cur;
         if (fl && !cur) disc = 1'b1;
         chk1("inst_rdvalid", o_inst_readdatavalid, exp_iv);
         chk1("data_rdvalid", o_data_readdatavalid, exp_dv);
         if (exp_iv) chk32("inst_rdata", o_inst_readdata, rdat);
         if (exp_dv) chk32("data_rdata", o_data_readdata, rdat);
         if (beat) begin
            beat_idx++;
            remaining--;
            if (remaining == 0) fin = 1'b1;
         end
         if (o_read || o_write) begin
            chk1("cmd_after_accept", accepted, 1'b0);
            if (cmd_cycles == 0) chk32("grant_latency", since, (done_cnt == 0) ? 1 : 2);
            chk1("owner", o_owner, cur);
            chk32("addr", o_addr, cur ? da : ia);
            chk1("mem_read", o_read, cur ? (dr && !dw) : 1'b1);
            chk1("mem_write", o_write, cur ? dw : 1'b0);
            chk32("burstcount", {24'd0, o_burstcount}, {24'd0, cur ? db : ib});
            chk32("byteenable", {28'd0, o_byteenable}, {28'd0, cur ? be : 4'hF});
            if (cur && dw) chk32("writedata", o_writedata, wd);
            chk1("inst_wait_cmd", o_inst_waitrequest, cur ? 1'b1 : i_waitrequest);
            chk1("data_wait_cmd", o_data_waitrequest, cur ? i_waitrequest : 1'b1);
            cmd_cycles++;
            if (!i_waitrequest) begin
               if (!rnd) chk32("stall_cycles", cmd_cycles, stall + 1);
               accepted = 1'b1;
               if (cur) drop_d = 1'b1; else drop_i = 1'b1;
               if (cur && dw) fin = 1'b1;
               else begin
                  blen = cur ? db : ib;
                  remaining = (blen == '0) ? 1 : int'(blen);
               end
            end
         end else begin
            chk1("inst_wait_idle", o_inst_waitrequest, 1'b1);
            chk1("data_wait_idle", o_data_waitrequest, 1'b1);
         end
         if (fin) begin
            last_m = cur;  done_cnt++;  cur = !cur;
            accepted = 1'b0;  disc = 1'b0;  beat_idx = 0;  cmd_cycles = 0;  since = 0;
         end
         since++;
         tick();
      end
      if (done_cnt < need) chk32("round_timeout", done_cnt, need);
      idle_inputs();
      chk1("stray_quiet", o_stray_err, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      i_inst_addr = '0; i_inst_burstcount = '0; i_data_addr = '0; i_data_writedata = '0;
      i_data_byteenable = '0; i_data_burstcount = '0; i_readdata = '0;
      idle_inputs();
      do_reset();

      // Single fetch burst of 4 from 0x100, data 0xA0..0xA3.
      run_round(1, 0, 0, 0, 8'd4, 8'd0, 0, 0, -1, 32'hA0, 32'h100, 32'h0, 32'h0, 4'h0);

      // From reset, fetch and data write collide: fetch first, write after one idle cycle.
      do_reset();
      run_round(1, 1, 1, 0, 8'd4, 8'd1, 0, 0, -1, 32'hB0, 32'h100, 32'h200, 32'hDEADBEEF, 4'hF);

      // Continuous contention: grants alternate inst, data, inst, data.
      run_round(1, 1, 0, 1, 8'd2, 8'd3, 0, 0, -1, 32'h10, 32'h300, 32'h400, 32'h0, 4'h3);
      run_round(1, 1, 0, 1, 8'd0, 8'd2, 0, 0, -1, 32'h20, 32'h500, 32'h600, 32'h0, 4'hC);

      // Data write stalled three cycles, with a concurrent read request losing to the write.
      run_round(0, 1, 1, 1, 8'd0, 8'd4, 0, 3, -1, 32'h0, 32'h0, 32'h700, 32'h12345678, 4'h5);

      // Flush on the second beat of a fetch burst, then a normal fetch.
      run_round(1, 0, 0, 0, 8'd4, 8'd0, 0, 0, 1, 32'hC0, 32'h800, 32'h0, 32'h0, 4'h0);
      run_round(1, 0, 0, 0, 8'd2, 8'd0, 0, 0, -1, 32'hD0, 32'h900, 32'h0, 32'h0, 4'h0);

      // Randomized rounds.
      for (int r = 0; r < 40; r++) begin
         int sel;
         bit rw, rr;
         sel = int'($urandom_range(1, 3));
         rw = ($urandom_range(0, 1) == 1);
         rr = rw ? ($urandom_range(0, 1) == 1) : 1'b1;
         run_round(sel[0], sel[1], rw, rr, 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
                   1, 0, int'($urandom_range(0, 4)) - 1, 32'h0,
                   $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)));
      end

      // Stray beat while idle: dropped, sticky error until reset.
      i_readdatavalid = 1'b1;
      i_readdata = 32'h5A5A5A5A;
      #1;
      chk1("stray_inst_rdvalid", o_inst_readdatavalid, 1'b0);
      chk1("stray_data_rdvalid", o_data_readdatavalid, 1'b0);
      tick();
      i_readdatavalid = 1'b0;
      chk1("stray_set", o_stray_err, 1'b1);
      tick();
      tick();
      chk1("stray_held", o_stray_err, 1'b1);
      do_reset();

      // After reset the fetch port wins the first tie again.
      run_round(1, 1, 0, 1, 8'd1, 8'd1, 0, 0, -1, 32'hE0, 32'hA00, 32'hB00, 32'h0, 4'hF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single Avalon-MM memory master between two requesters: the instruction-fetch port and the data load/store port.
- Round-robin arbitration, one transaction (write beat or read burst) per grant.
- The grant is held until all read beats of a burst have returned, so readdata routing needs no tag FIFO.
- Supports an instruction flush that discards in-flight fetch data after a jump.

Parameters:
p_addr_bits, 32, memory address width (MEM_ADDR_BITS)
p_data_bits, 32, data word width (WORD_BITS)
p_burst_bits, 8, burstcount width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
i_inst_addr  in  p_addr_bits  fetch address
i_inst_read  in  1  fetch read request
i_inst_burstcount  in  p_burst_bits  fetch burst length
o_inst_waitrequest  out  1  fetch command not accepted
o_inst_readdata  out  p_data_bits  fetch return data
o_inst_readdatavalid  out  1  fetch return beat valid
i_inst_flush  in  1  discard remaining beats of the current fetch burst
i_data_addr  in  p_addr_bits  data address
i_data_read  in  1  data read request
i_data_write  in  1  data write request (single beat)
i_data_writedata  in  p_data_bits  write data
i_data_byteenable  in  p_data_bits/8  byte enables
i_data_burstcount  in  p_burst_bits  data read burst length
o_data_waitrequest  out  1  data command not accepted
o_data_readdata  out  p_data_bits  data return data
o_data_readdatavalid  out  1  data return beat valid
o_addr  out  p_addr_bits  memory address
o_read  out  1  memory read
o_write  out  1  memory write
o_writedata  out  p_data_bits  memory write data
o_byteenable  out  p_data_bits/8  memory byte enables
o_burstcount  out  p_burst_bits  memory burst length
i_waitrequest  in  1  memory stall
i_readdata  in  p_data_bits  memory read data
i_readdatavalid  in  1  memory read beat valid
o_owner  out  1  current grant, 0 = inst, 1 = data
o_stray_err  out  1  sticky: readdatavalid seen outside RDATA

Behaviour:
- States: IDLE, CMD, RDATA. Reset values:
  - state = IDLE, r_owner = 0, r_last = 1 (inst wins the first tie), beat counter = 0.
  - o_read = o_write = 0, both readdatavalids = 0, o_stray_err = 0.
  - Both waitrequests = 1.
- IDLE:
  - inst request = i_inst_read; data request = i_data_read | i_data_write.
  - Only one requesting: grant it. Both requesting: grant the one != r_last.
  - On grant: r_owner latched, go to CMD next cycle. Arbitration latency is 1 cycle. No memory command is driven in IDLE.
- CMD:
  - o_addr, o_read, o_write, o_writedata, o_byteenable and o_burstcount pass combinationally from the owner.
  - For inst: o_write = 0, byteenable = all ones.
  - Owner's waitrequest = i_waitrequest. Non-owner's waitrequest = 1 at all times.
  - Accept (owner request & !i_waitrequest):
    - Write: r_last <= owner, go to IDLE.
    - Read: latch burst length (0 treated as 1), beat counter = 0, go to RDATA.
  - Owner deasserts both read and write while in CMD: go to IDLE with no command issued; r_last is unchanged.
  - If i_data_read and i_data_write are both high, the write takes precedence.
- RDATA:
  - o_read = o_write = 0; both waitrequests = 1.
  - Each i_readdatavalid increments the counter and is routed combinationally: readdata drives both outputs; only the owner's readdatavalid is asserted.
  - On the beat where counter+1 == latched length: r_last <= owner, go to IDLE. The next arbitration happens in the following cycle.
- Flush:
  - i_inst_flush while owner = inst and in CMD or RDATA: set r_discard.
  - While r_discard is set, inst beats are still counted but o_inst_readdatavalid is forced to 0. r_discard clears on entry to IDLE.
  - A flush in the same cycle as a beat suppresses that beat.
  - A flush in CMD before accept still lets the command issue. The burst is drained, never aborted, because memory will return it.
  - Flush with owner = data, or in IDLE: ignored.
- i_readdatavalid in IDLE or CMD: beat dropped, o_stray_err <= 1; cleared only by rst.
- Counter arithmetic is p_burst_bits wide; no wrap, since burst length <= 2^p_burst_bits - 1.
- rst mid-burst: immediate return to IDLE. Beats still returning afterwards set o_stray_err. The memory subsystem must be reset together with this block.

Test Plan:
- Inst read addr 0x100, burst 4, waitrequest low, 4 beats 0xA0..0xA3 -> o_read high 1 cycle in CMD with burstcount 4; o_inst_readdatavalid high ×4 carrying 0xA0..0xA3; back to IDLE; o_data_readdatavalid never asserted.
- Inst read and data write (0x200, 0xDEADBEEF, be 0xF) requested in the same cycle from reset -> inst granted first; data write issued in the cycle after the 4th inst beat plus one IDLE cycle; o_data_waitrequest stays 1 until then.
- Both requesting continuously for 4 transactions -> grants alternate inst, data, inst, data.
- Data write held with i_waitrequest high for 3 cycles -> o_write, address and data stable for 4 cycles; o_data_waitrequest mirrors i_waitrequest; single accept.
- Inst burst 4, i_inst_flush pulsed after beat 1 -> only beat 0 delivered; 4 beats consumed; arbiter returns to IDLE after beat 3; next grant proceeds normally.
- i_readdatavalid pulsed in IDLE -> no readdatavalid output; o_stray_err = 1 and held; rst clears it to 0.
